io_bus_bridge: RTL
==================

# io_bus_bridge

Parametrised Avalon-MM slave to external IO-bus master bridge. It replaces the fixed 16-bit io_* bridge in the HPS/FPGA system. It converts HPS-side read/write transfers into the io_bus_enable/io_acknowledge handshake, with configurable widths, a per-transfer acknowledge timeout, a saturating error counter, and a synchronised, edge-latched IRQ.

## Interface
Parameters:
- DATA_W, 16: IO data width; must be a multiple of 8.
- ADDR_W, 16: IO address width.
- TIMEOUT, 255: maximum cycles io_bus_enable stays high waiting for acknowledge; range 1..65535.
- BE_W, DATA_W/8: byte-enable width; derived, not overridable.

Ports:
- clk  in  1  single system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  ADDR_W  transfer address.
- avs_read  in  1  read request; held until waitrequest is low.
- avs_write  in  1  write request; held until waitrequest is low.
- avs_byteenable  in  BE_W  byte lanes.
- avs_writedata  in  DATA_W  write data.
- avs_readdata  out  DATA_W  read data; valid when waitrequest is low on a read.
- avs_waitrequest  out  1  stall.
- io_address  out  ADDR_W  latched address.
- io_bus_enable  out  1  transfer strobe.
- io_byte_enable  out  BE_W  latched byte enables.
- io_rw  out  1  1 = read, 0 = write.
- io_write_data  out  DATA_W  latched write data.
- io_read_data  in  DATA_W  device read data.
- io_acknowledge  in  1  device completion; synchronous to clk.
- io_irq  in  1  asynchronous device interrupt.
- irq_ack  in  1  one-cycle pulse; clears pending IRQ.
- irq  out  1  pending interrupt.
- err_count  out  8  saturating timeout count.

## Operation
- FSM states are IDLE, BUS, DONE, RELEASE.
- IDLE:
  - avs_waitrequest=1 except in DONE.
  - On avs_read|avs_write: latch address, byteenable, writedata and io_rw=avs_read, then go to BUS. If read and write are both high, read wins.
- BUS:
  - io_bus_enable=1 and the cycle counter increments.
  - io_acknowledge=1: capture io_read_data (reads only) and go to DONE.
  - Counter reaches TIMEOUT with no ack: go to DONE with the timeout flag set. readdata is all-ones; err_count increments and saturates at 255.
  - If ack arrives on the same cycle the counter reaches TIMEOUT, ack wins and no error is recorded.
- DONE:
  - io_bus_enable=0 and avs_waitrequest=0 for exactly one cycle, then go to RELEASE.
- RELEASE:
  - Return to IDLE once io_acknowledge=0. A new request stalls here until then.
- Writes with avs_byteenable=0 still run a bus cycle.
- IRQ path:
  - io_irq passes through a 2-flop synchroniser. A rising edge sets pending.
  - irq_ack clears pending. A simultaneous edge and irq_ack leaves pending=1.
  - irq = pending.
- Reset mid-transfer aborts immediately to IDLE. io_bus_enable drops asynchronously and no completion is returned to the master.

## Timing
- Reset values: avs_waitrequest=1, io_bus_enable=0, io_rw=0, io_address=0, io_byte_enable=0, io_write_data=0, avs_readdata=0, irq=0, err_count=0, synchroniser flops=0.
- Request seen at cycle 0 → io_bus_enable=1 from cycle 1.
- Ack seen at cycle k (k≥1) → DONE at cycle k+1; waitrequest low and readdata valid in that cycle.
- Minimum transfer: ack at cycle 1 gives completion at cycle 2, a 3-cycle occupancy including RELEASE.
- Timeout: io_bus_enable is high for exactly TIMEOUT cycles, then DONE.
- IRQ latency: io_irq rising edge → irq high 3 cycles later.
- irq_ack → irq low next cycle.
- All io_* outputs are registered and stable while io_bus_enable=1.

## Structure
- Package io_bridge_pkg holds:
  - state enum (IDLE, BUS, DONE, RELEASE).
  - ERR_W=8.
  - SYNC_STAGES=2.
  - TO_W function = $clog2(TIMEOUT+1).
- Sub-module io_irq_sync contains the synchroniser, edge detector and pending flop. The parent holds the FSM, the counters and the data latches.

## Test plan
- Read at addr 0x0040, device acks at cycle 3 with 0xBEEF:
  - io_bus_enable high for cycles 1-3 with io_rw=1.
  - waitrequest low at cycle 4 with readdata=0xBEEF.
- Write 0x1234 with byteenable 2'b10, ack at cycle 1:
  - io_write_data=0x1234, io_byte_enable=2'b10, io_rw=0.
  - Completion at cycle 2.
- TIMEOUT=8, no ack:
  - io_bus_enable high for exactly 8 cycles.
  - readdata=0xFFFF, err_count=1.
  - After 256 timeouts, err_count stays at 255.
- Ack held high 5 cycles after DONE with a back-to-back request queued:
  - FSM waits in RELEASE.
  - Next io_bus_enable rises only after ack falls.
- io_irq pulse at cycle 10:
  - irq=1 at cycle 13.
  - irq_ack at cycle 20 coinciding with a second io_irq edge: irq stays 1.
  - irq_ack alone at cycle 25: irq=0 at cycle 26.
- reset_n asserted during BUS: io_bus_enable=0 immediately; after release the FSM is in IDLE and waitrequest=1.

Source files
------------

// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared types and constants for the IO-bus bridge.
//   state_t      bridge FSM state encoding
//   ERR_W        width of the saturating timeout counter
//   SYNC_STAGES  depth of the io_irq synchroniser
//   to_w()       width of a counter that must hold the value TIMEOUT
package io_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int ERR_W       = 8;
  localparam int SYNC_STAGES = 2;

  function automatic int to_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/io_irq_sync.sv
// io_irq_sync: brings the asynchronous device interrupt into the clk domain,
// detects its rising edge and holds a pending flag until acknowledged.
//   clk, reset_n  system clock, async active-low reset
//   io_irq        asynchronous device interrupt
//   irq_ack       one-cycle pulse clearing the pending flag
//   irq           pending interrupt
module io_irq_sync
  import io_bridge_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic io_irq,
  input  logic irq_ack,
  output logic irq
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pending_q;
  logic                   rise;

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign irq  = pending_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], io_irq};
      prev_q <= sync_q[SYNC_STAGES-1];
      // A new edge in the same cycle as an acknowledge must not be lost.
      if (rise)
        pending_q <= 1'b1;
      else if (irq_ack)
        pending_q <= 1'b0;
    end
  end

endmodule

// File: rtl/io_bus_bridge.sv
// io_bus_bridge: Avalon-MM slave to external IO-bus master bridge.
//   clk, reset_n          system clock, async active-low reset
//   avs_*                 Avalon-MM slave side (read/write held while waitrequest=1)
//   io_address/io_rw/io_byte_enable/io_write_data  latched transfer fields
//   io_bus_enable         transfer strobe; io_acknowledge ends it
//   io_read_data          device read data, captured on acknowledge
//   io_irq, irq_ack, irq  synchronised, edge-latched interrupt
//   err_count             saturating count of acknowledge timeouts
//
// state   | meaning
// IDLE    | waiting for avs_read/avs_write; fields latched on request
// BUS     | io_bus_enable high, waiting for ack or TIMEOUT cycles
// DONE    | one-cycle completion, avs_waitrequest low
// RELEASE | waiting for the device to drop io_acknowledge
module io_bus_bridge
  import io_bridge_pkg::*;
#(
  parameter  int DATA_W  = 16,
  parameter  int ADDR_W  = 16,
  parameter  int TIMEOUT = 255,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [BE_W-1:0]   avs_byteenable,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] io_address,
  output logic              io_bus_enable,
  output logic [BE_W-1:0]   io_byte_enable,
  output logic              io_rw,
  output logic [DATA_W-1:0] io_write_data,
  input  logic [DATA_W-1:0] io_read_data,
  input  logic              io_acknowledge,
  input  logic              io_irq,
  input  logic              irq_ack,
  output logic              irq,
  output logic [ERR_W-1:0]  err_count
);

  localparam int CNT_W = to_w(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             bus_en_d, wait_d;
  logic             latch, capture, timeout;

  always_comb begin
    state_d  = state_q;
    bus_en_d = 1'b0;
    wait_d   = 1'b1;
    latch    = 1'b0;
    capture  = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (avs_read || avs_write) begin
          state_d  = BUS;
          latch    = 1'b1;
          bus_en_d = 1'b1;
        end
      end
      BUS: begin
        bus_en_d = 1'b1;
        // Acknowledge is checked first so a late ack on the last cycle wins.
        if (io_acknowledge) begin
          state_d  = DONE;
          capture  = 1'b1;
          bus_en_d = 1'b0;
          wait_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d  = DONE;
          timeout  = 1'b1;
          bus_en_d = 1'b0;
          wait_d   = 1'b0;
        end
      end
      DONE:    state_d = RELEASE;
      RELEASE: if (!io_acknowledge) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe and stall are flops so the bus sees glitch-free, registered levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      io_bus_enable   <= 1'b0;
      avs_waitrequest <= 1'b1;
      cnt_q           <= '0;
      io_address      <= '0;
      io_byte_enable  <= '0;
      io_write_data   <= '0;
      io_rw           <= 1'b0;
      avs_readdata    <= '0;
      err_count       <= '0;
    end else begin
      state_q         <= state_d;
      io_bus_enable   <= bus_en_d;
      avs_waitrequest <= wait_d;
      // Counter holds the number of cycles io_bus_enable has been high.
      if (latch)
        cnt_q <= CNT_W'(1);
      else if (state_q == BUS)
        cnt_q <= cnt_q + CNT_W'(1);
      if (latch) begin
        io_address     <= avs_address;
        io_byte_enable <= avs_byteenable;
        io_write_data  <= avs_writedata;
        io_rw          <= avs_read;
      end
      if (capture && io_rw)
        avs_readdata <= io_read_data;
      else if (timeout)
        avs_readdata <= '1;
      if (timeout && (err_count != '1))
        err_count <= err_count + ERR_W'(1);
    end
  end

  io_irq_sync u_irq_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .io_irq  (io_irq),
    .irq_ack (irq_ack),
    .irq     (irq)
  );

endmodule
